// File: rtl/mul_hilo_writeback_if.sv
// Product handshake (multiplier -> writeback) and bus handshake (writeback -> arbiter)
// for mul_hilo_writeback. The slave modport is the writeback stage's view.
interface mul_hilo_writeback_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  prod_valid;
    logic                  prod_ready;
    logic [2*DATA_W-1:0]   product_in;
    logic                  bus_valid;
    logic                  bus_ready;
    logic [DATA_W-1:0]     bus_out;
    logic                  bus_dst;

    modport master (
        output prod_valid,
        output product_in,
        output bus_ready,
        input  prod_ready,
        input  bus_valid,
        input  bus_out,
        input  bus_dst
    );

    modport slave (
        input  prod_valid,
        input  product_in,
        input  bus_ready,
        output prod_ready,
        output bus_valid,
        output bus_out,
        output bus_dst
    );
endinterface

// File: rtl/mul_hilo_writeback.sv
// Booth multiplier writeback stage: captures the 2*DATA_W product, writes LO then HI over
// the DATA_W bus and keeps the HI/LO registers. Optional sticky overflow via MUL_OVF_FLAG_EN.
module mul_hilo_writeback #(
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_HILO = '0
) (
    input  logic                 clk,
    input  logic                 clr,
    mul_hilo_writeback_if.slave  wb,
    output logic [DATA_W-1:0]    hi_q,
    output logic [DATA_W-1:0]    lo_q,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR_LO = 2'd1;
    localparam logic [1:0] S_WR_HI = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic [DATA_W-1:0]   hi_d, lo_d;
    logic                capture;

    always_comb begin
        capture = (state_q == S_IDLE) && wb.prod_valid;
    end

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    z_d     = wb.product_in;
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: begin
                if (wb.bus_ready) begin
                    lo_d    = z_q[DATA_W-1:0];
                    state_d = S_WR_HI;
                end
            end
            S_WR_HI: begin
                if (wb.bus_ready) begin
                    hi_d    = z_q[2*DATA_W-1:DATA_W];
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are pure functions of state and Z, so they hold stable under backpressure.
    always_comb begin
        wb.prod_ready = (state_q == S_IDLE);
        wb.bus_valid  = (state_q == S_WR_LO) || (state_q == S_WR_HI);
        wb.bus_dst    = (state_q == S_WR_HI);
        case (state_q)
            S_WR_LO: wb.bus_out = z_q[DATA_W-1:0];
            S_WR_HI: wb.bus_out = z_q[2*DATA_W-1:DATA_W];
            default: wb.bus_out = '0;
        endcase
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // A clr that abandons a transfer in WR_HI keeps the LO beat that was already accepted.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            z_q     <= '0;
            hi_q    <= RESET_HILO;
            lo_q    <= (state_q == S_WR_HI) ? lo_q : RESET_HILO;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

`ifdef MUL_OVF_FLAG_EN
    logic ovf_q, ovf_d;
    logic prod_fits;

    // The product fits in DATA_W signed bits when its top DATA_W+1 bits are a pure sign extension.
    always_comb begin
        prod_fits = (&wb.product_in[2*DATA_W-1:DATA_W-1]) | ~(|wb.product_in[2*DATA_W-1:DATA_W-1]);
        ovf_d     = ovf_q | (capture & ~prod_fits);
        ovf       = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`else
    always_comb begin
        ovf = 1'b0;
    end
`endif

endmodule

// File: tb/tb_mul_hilo_writeback.sv
// Scoreboard bench for mul_hilo_writeback: expected bus beats are queued when a product
// is offered and popped as the DUT presents accepted beats.
module tb_mul_hilo_writeback;

    localparam int unsigned DW   = 32;
    localparam logic [31:0] RHL  = 32'hA5A5_0F0F;
`ifdef MUL_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        dst;
    } beat_t;

    logic        clk;
    logic        clr;
    logic [31:0] hi_q, lo_q;
    logic        busy, done, ovf;

    beat_t sb[$];
    int    vectors;
    int    miscompares;

    mul_hilo_writeback_if #(.DATA_W(DW)) wb ();

    mul_hilo_writeback #(
        .DATA_W     (DW),
        .RESET_HILO (RHL)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .wb   (wb),
        .hi_q (hi_q),
        .lo_q (lo_q),
        .busy (busy),
        .done (done),
        .ovf  (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset(input string tag);
        clr = 1'b1;
        wb.prod_valid = 1'b0;
        wb.bus_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, wb.bus_valid, wb.bus_dst, wb.prod_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL %s ctrl: got busy/done/bv/dst/pr=%b want 00001", tag,
                     {busy, done, wb.bus_valid, wb.bus_dst, wb.prod_ready});
        end
        vectors++;
        if (wb.bus_out !== 32'h0) begin
            miscompares++;
            $display("FAIL %s bus_out: got %h want 00000000", tag, wb.bus_out);
        end
        vectors++;
        if (hi_q !== RHL || lo_q !== RHL) begin
            miscompares++;
            $display("FAIL %s hilo: got hi=%h lo=%h want %h", tag, hi_q, lo_q, RHL);
        end
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ovf: got %b want 0", tag, ovf);
        end
        clr = 1'b0;
    endtask

    // One product through the stage; LO beat is held off for `stall` cycles.
    task automatic xfer(input logic [63:0] p, input int stall, input string tag);
        int          cyc;
        int          lo_wait;
        bit          seen_done;
        logic [31:0] held_out;
        logic        held_dst;
        beat_t       exp;
        @(negedge clk);
        wb.prod_valid = 1'b1;
        wb.product_in = p;
        wb.bus_ready  = 1'b1;
        sb.push_back('{data: p[31:0],  dst: 1'b0});
        sb.push_back('{data: p[63:32], dst: 1'b1});
        vectors++;
        if (wb.prod_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s prod_ready_idle: got %b want 1", tag, wb.prod_ready);
        end
        cyc = 0; lo_wait = 0; seen_done = 1'b0;
        held_out = '0; held_dst = 1'b0;
        while (!seen_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            wb.prod_valid = 1'b0;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                vectors++;
                if (cyc != 3 + stall || wb.bus_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s done_latency: got cycle %0d bv=%b want cycle %0d bv=0",
                             tag, cyc, wb.bus_valid, 3 + stall);
                end
            end else begin
                vectors++;
                if ({wb.bus_valid, busy, wb.prod_ready} !== 3'b110) begin
                    miscompares++;
                    $display("FAIL %s busy_state: cycle %0d got bv/busy/pr=%b want 110",
                             tag, cyc, {wb.bus_valid, busy, wb.prod_ready});
                end
                if (wb.bus_valid === 1'b1 && wb.bus_dst === 1'b0) begin
                    if (lo_wait > 0) begin
                        vectors++;
                        if (wb.bus_out !== held_out || wb.bus_dst !== held_dst) begin
                            miscompares++;
                            $display("FAIL %s hold_stable: got %h/%b want %h/%b",
                                     tag, wb.bus_out, wb.bus_dst, held_out, held_dst);
                        end
                    end
                    held_out = wb.bus_out;
                    held_dst = wb.bus_dst;
                    wb.bus_ready = (lo_wait >= stall);
                    lo_wait++;
                end else begin
                    wb.bus_ready = 1'b1;
                end
                if (wb.bus_valid === 1'b1 && wb.bus_ready === 1'b1) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL %s beat_unexpected: got %h/%b want none", tag, wb.bus_out, wb.bus_dst);
                    end else begin
                        exp = sb.pop_front();
                        if (wb.bus_out !== exp.data || wb.bus_dst !== exp.dst) begin
                            miscompares++;
                            $display("FAIL %s beat: got %h/%b want %h/%b",
                                     tag, wb.bus_out, wb.bus_dst, exp.data, exp.dst);
                        end
                    end
                end
            end
        end
        if (!seen_done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no done in 40 cycles want done at %0d", tag, 3 + stall);
        end
        vectors++;
        if (lo_q !== p[31:0] || hi_q !== p[63:32]) begin
            miscompares++;
            $display("FAIL %s hilo: got hi=%h lo=%h want hi=%h lo=%h", tag, hi_q, lo_q, p[63:32], p[31:0]);
        end
    endtask

    task automatic test_basic();
        xfer(64'hFFFF_FFFF_FFFF_FFEB, 0, "basic");
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL basic ovf: got %b want 0", ovf);
        end
    endtask

    task automatic test_backpressure();
        xfer(64'hFFFF_FFFF_8000_0000, 5, "backpressure");
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure ovf: got %b want 0", ovf);
        end
    endtask

    task automatic test_back_to_back();
        int    cyc;
        int    ndone;
        int    cap2;
        beat_t exp;
        @(negedge clk);
        wb.prod_valid = 1'b1;
        wb.product_in = 64'h1;
        wb.bus_ready  = 1'b1;
        sb.push_back('{data: 32'h1, dst: 1'b0});
        sb.push_back('{data: 32'h0, dst: 1'b1});
        cyc = 0; ndone = 0; cap2 = -1;
        while (ndone < 2 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                wb.product_in = 64'h2;
                sb.push_back('{data: 32'h2, dst: 1'b0});
                sb.push_back('{data: 32'h0, dst: 1'b1});
            end
            if (cap2 >= 0) wb.prod_valid = 1'b0;
            if (wb.prod_ready === 1'b1 && cap2 < 0) begin
                cap2 = cyc;
                vectors++;
                if (cyc != 4) begin
                    miscompares++;
                    $display("FAIL b2b second_capture: got cycle %0d want 4", cyc);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                vectors++;
                if (cyc != 4 * ndone - 1) begin
                    miscompares++;
                    $display("FAIL b2b done%0d: got cycle %0d want %0d", ndone, cyc, 4 * ndone - 1);
                end
            end
            if (wb.bus_valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b beat_unexpected: got %h/%b want none", wb.bus_out, wb.bus_dst);
                end else begin
                    exp = sb.pop_front();
                    if (wb.bus_out !== exp.data || wb.bus_dst !== exp.dst) begin
                        miscompares++;
                        $display("FAIL b2b beat: got %h/%b want %h/%b", wb.bus_out, wb.bus_dst, exp.data, exp.dst);
                    end
                end
            end
        end
        wb.prod_valid = 1'b0;
        vectors++;
        if (ndone != 2) begin
            miscompares++;
            $display("FAIL b2b timeout: got %0d done pulses want 2", ndone);
        end
        vectors++;
        if (lo_q !== 32'h2 || hi_q !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b hilo: got hi=%h lo=%h want hi=00000000 lo=00000002", hi_q, lo_q);
        end
    endtask

    task automatic test_ovf_boundary();
        xfer(64'h0000_0000_7FFF_FFFF, 0, "ovf_max_pos");
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_max_pos ovf: got %b want 0", ovf);
        end
        xfer(64'h0000_0000_8000_0000, 0, "ovf_2p31");
        vectors++;
        if (ovf !== OVF_EN) begin
            miscompares++;
            $display("FAIL ovf_2p31 ovf: got %b want %b", ovf, OVF_EN);
        end
    endtask

    task automatic test_overflow();
        xfer(64'h0000_0001_0000_0000, 0, "ovf_first");
        vectors++;
        if (ovf !== OVF_EN) begin
            miscompares++;
            $display("FAIL ovf_first ovf: got %b want %b", ovf, OVF_EN);
        end
        xfer(64'h2, 0, "ovf_sticky");
        vectors++;
        if (ovf !== OVF_EN) begin
            miscompares++;
            $display("FAIL ovf_sticky ovf: got %b want %b", ovf, OVF_EN);
        end
    endtask

    task automatic test_reset_mid_hi();
        beat_t exp;
        @(negedge clk);
        wb.prod_valid = 1'b1;
        wb.product_in = 64'h0000_0001_0000_0002;
        wb.bus_ready  = 1'b1;
        sb.push_back('{data: 32'h2, dst: 1'b0});
        @(negedge clk);
        wb.prod_valid = 1'b0;
        vectors++;
        if (wb.bus_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL midhi lo_beat: got bv=%b want 1", wb.bus_valid);
        end else begin
            exp = sb.pop_front();
            if (wb.bus_out !== exp.data || wb.bus_dst !== exp.dst) begin
                miscompares++;
                $display("FAIL midhi lo_beat: got %h/%b want %h/%b", wb.bus_out, wb.bus_dst, exp.data, exp.dst);
            end
        end
        @(negedge clk);
        vectors++;
        if (wb.bus_valid !== 1'b1 || wb.bus_dst !== 1'b1) begin
            miscompares++;
            $display("FAIL midhi in_wr_hi: got bv=%b dst=%b want 1/1", wb.bus_valid, wb.bus_dst);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        vectors++;
        if (lo_q !== 32'h2 || hi_q !== RHL) begin
            miscompares++;
            $display("FAIL midhi hilo: got hi=%h lo=%h want hi=%h lo=00000002", hi_q, lo_q, RHL);
        end
        vectors++;
        if ({busy, done, wb.bus_valid, wb.prod_ready} !== 4'b0001 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL midhi ctrl: got busy/done/bv/pr=%b ovf=%b want 0001 ovf=0",
                     {busy, done, wb.bus_valid, wb.prod_ready}, ovf);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || wb.bus_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midhi after_clr%0d: got done=%b bv=%b want 0/0", i, done, wb.bus_valid);
            end
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        clr           = 1'b1;
        wb.prod_valid = 1'b0;
        wb.product_in = '0;
        wb.bus_ready  = 1'b0;

        test_reset("reset_power_on");
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_ovf_boundary();
        test_reset("reset_clears_ovf");
        test_overflow();
        test_reset("reset_idle");
        test_reset_mid_hi();

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d beats left want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
